// File: rtl/cpu_timing_pkg.sv
// Shared timing encodings for the CPU core: run-control modes and the
// phase-sequencer state machine, also decoded by the control unit.
package cpu_timing_pkg;

  // Encoding 2'b11 is not listed and is treated as halt by every consumer.
  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_STEP = 2'b01,
    MODE_HALT = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

endpackage

// File: rtl/phase_window.sv
// Combinational decode of a phase range [START, START+LEN).
// LEN=0 gives a window that never opens.
module phase_window #(
  parameter int PH_W  = 3,
  parameter int START = 0,
  parameter int LEN   = 1
) (
  input  logic [PH_W-1:0] phase,
  output logic            hit
);

  localparam logic [31:0] START_W = 32'(START);
  localparam logic [31:0] LEN_W   = 32'(LEN);

  logic [31:0] offset;

  // Unsigned wrap turns phase < START into a huge offset, so one compare
  // covers both bounds.
  assign offset = 32'(phase) - START_W;
  assign hit    = (offset < LEN_W);

endmodule

// File: rtl/cpu_phase_seq.sv
// Instruction-cycle phase sequencer: divides clk into PHASES-long cycles,
// with run/step/halt control, stall freeze and registered strobes.
module cpu_phase_seq
  import cpu_timing_pkg::*;
#(
  parameter  int PHASES      = 8,
  parameter  int ALU_PHASE   = 0,
  parameter  int ALU_LEN     = 1,
  parameter  int FETCH_START = 2,
  parameter  int FETCH_LEN   = 4,
  parameter  int CNT_W       = 16,
  localparam int PH_W        = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              step,
  input  logic              stall,
  output logic              clk_n,
  output logic              fetch,
  output logic              alu_clk,
  output logic [PH_W-1:0]   phase,
  output logic [PHASES-1:0] phase_oh,
  output logic              cyc_start,
  output logic              running,
  output logic [CNT_W-1:0]  cyc_cnt,
  output state_e            dbg_state
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(PHASES - 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hold_q;
  logic              fetch_q, alu_q, start_q;
  logic              fetch_hit, alu_hit;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (state_q)
      // hold_q keeps IDLE through the first edge after reset release.
      ST_IDLE: begin
        phase_d = '0;
        if (!hold_q) state_d = (mode == MODE_RUN) ? ST_RUN : ST_WAIT;
      end
      ST_RUN: begin
        if (!stall) begin
          if (phase_q == LAST_PH) begin
            phase_d = '0;
            cnt_d   = cnt_q + CNT_W'(1);
            if (mode != MODE_RUN) state_d = ST_WAIT;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      ST_WAIT: begin
        phase_d = '0;
        if ((mode == MODE_RUN) || ((mode == MODE_STEP) && step)) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Strobes decode the next-state phase so the registered copy lines up
  // with the phase register.
  phase_window #(.PH_W(PH_W), .START(FETCH_START), .LEN(FETCH_LEN)) u_fetch_win (
    .phase (phase_d),
    .hit   (fetch_hit)
  );

  phase_window #(.PH_W(PH_W), .START(ALU_PHASE), .LEN(ALU_LEN)) u_alu_win (
    .phase (phase_d),
    .hit   (alu_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      hold_q  <= 1'b1;
      fetch_q <= 1'b0;
      alu_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      hold_q  <= 1'b0;
      fetch_q <= (state_d == ST_RUN) && fetch_hit;
      alu_q   <= (state_d == ST_RUN) && alu_hit;
      start_q <= (state_d == ST_RUN) && (phase_d == '0);
    end
  end

  assign clk_n     = ~clk;
  assign fetch     = fetch_q;
  assign alu_clk   = alu_q;
  assign cyc_start = start_q;
  assign phase     = phase_q;
  assign cyc_cnt   = cnt_q;
  assign running   = (state_q == ST_RUN);
  assign phase_oh  = running ? (PHASES'(1) << phase_q) : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_phase_seq.sv
// Directed bench for cpu_phase_seq: default, 4-bit counter and 5-phase
// instances share clock and control inputs; outputs sampled on negedge.
module tb_cpu_phase_seq;
  import cpu_timing_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       step;
  logic       stall;

  // default instance
  logic        a_clk_n, a_fetch, a_alu_clk, a_cyc_start, a_running;
  logic [2:0]  a_phase;
  logic [7:0]  a_phase_oh;
  logic [15:0] a_cyc_cnt;
  state_e      a_dbg_state;

  // CNT_W=4 instance
  logic        b_clk_n, b_fetch, b_alu_clk, b_cyc_start, b_running;
  logic [2:0]  b_phase;
  logic [7:0]  b_phase_oh;
  logic [3:0]  b_cyc_cnt;
  state_e      b_dbg_state;

  // PHASES=5 instance
  logic        c_clk_n, c_fetch, c_alu_clk, c_cyc_start, c_running;
  logic [2:0]  c_phase;
  logic [4:0]  c_phase_oh;
  logic [15:0] c_cyc_cnt;
  state_e      c_dbg_state;

  int tests_run;
  int tests_failed;

  cpu_phase_seq u_dut_a (
    .clk(clk), .rst(rst), .mode(mode), .step(step), .stall(stall),
    .clk_n(a_clk_n), .fetch(a_fetch), .alu_clk(a_alu_clk), .phase(a_phase),
    .phase_oh(a_phase_oh), .cyc_start(a_cyc_start), .running(a_running),
    .cyc_cnt(a_cyc_cnt), .dbg_state(a_dbg_state)
  );

  cpu_phase_seq #(.CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .mode(mode), .step(step), .stall(stall),
    .clk_n(b_clk_n), .fetch(b_fetch), .alu_clk(b_alu_clk), .phase(b_phase),
    .phase_oh(b_phase_oh), .cyc_start(b_cyc_start), .running(b_running),
    .cyc_cnt(b_cyc_cnt), .dbg_state(b_dbg_state)
  );

  cpu_phase_seq #(.PHASES(5), .FETCH_START(1), .FETCH_LEN(3), .ALU_PHASE(4), .ALU_LEN(1)) u_dut_c (
    .clk(clk), .rst(rst), .mode(mode), .step(step), .stall(stall),
    .clk_n(c_clk_n), .fetch(c_fetch), .alu_clk(c_alu_clk), .phase(c_phase),
    .phase_oh(c_phase_oh), .cyc_start(c_cyc_start), .running(c_running),
    .cyc_cnt(c_cyc_cnt), .dbg_state(c_dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs of the default and CNT_W=4 instances for one cycle.
  task automatic exp_a(input string tag, input bit run, input int ph, input int cnt);
    bit in_fetch;
    in_fetch = run && (ph >= 2) && (ph <= 5);
    check({tag, "/run"},     32'(a_running),   32'(run));
    check({tag, "/phase"},   32'(a_phase),     32'(ph));
    check({tag, "/fetch"},   32'(a_fetch),     32'(in_fetch));
    check({tag, "/alu"},     32'(a_alu_clk),   32'(run && ph == 0));
    check({tag, "/start"},   32'(a_cyc_start), 32'(run && ph == 0));
    check({tag, "/oh"},      32'(a_phase_oh),  run ? (32'd1 << ph) : 32'd0);
    check({tag, "/cnt"},     32'(a_cyc_cnt),   32'(cnt));
    check({tag, "/b_phase"}, 32'(b_phase),     32'(ph));
    check({tag, "/b_cnt"},   32'(b_cyc_cnt),   32'(cnt % 16));
  endtask

  task automatic exp_c(input string tag, input bit run, input int ph, input int cnt);
    check({tag, "/c_run"},   32'(c_running),   32'(run));
    check({tag, "/c_phase"}, 32'(c_phase),     32'(ph));
    check({tag, "/c_fetch"}, 32'(c_fetch),     32'(run && ph >= 1 && ph <= 3));
    check({tag, "/c_alu"},   32'(c_alu_clk),   32'(run && ph == 4));
    check({tag, "/c_start"}, 32'(c_cyc_start), 32'(run && ph == 0));
    check({tag, "/c_oh"},    32'(c_phase_oh),  run ? (32'd1 << ph) : 32'd0);
    check({tag, "/c_cnt"},   32'(c_cyc_cnt),   32'(cnt));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    mode  = MODE_RUN;
    step  = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Free run: cycle 0 is this negedge, rst released.
    rst = 1'b0;
    check("rst/state", 32'(a_dbg_state), 32'(ST_IDLE));
    check("rst/clk_n", 32'(a_clk_n), 32'd1);
    exp_a("rst", 1'b0, 0, 0);
    exp_c("rst", 1'b0, 0, 0);
    for (int cy = 1; cy <= 17; cy++) begin
      tick();
      if (cy < 2) begin
        check("idle/state", 32'(a_dbg_state), 32'(ST_IDLE));
        exp_a("idle", 1'b0, 0, 0);
        exp_c("idle", 1'b0, 0, 0);
      end else begin
        exp_a($sformatf("free%0d", cy), 1'b1, (cy - 2) % 8, (cy - 2) / 8);
        exp_c($sformatf("free%0d", cy), 1'b1, (cy - 2) % 5, (cy - 2) / 5);
      end
    end

    // Stall three clocks in phase 3.
    tick(); exp_a("pre_stall", 1'b1, 0, 2);
    for (int ph = 1; ph <= 3; ph++) begin
      tick(); exp_a("pre_stall", 1'b1, ph, 2);
    end
    stall = 1'b1;
    repeat (3) begin
      tick(); exp_a("stall", 1'b1, 3, 2);
    end
    stall = 1'b0;
    for (int ph = 4; ph <= 7; ph++) begin
      tick(); exp_a("post_stall", 1'b1, ph, 2);
    end
    tick(); exp_a("post_stall", 1'b1, 0, 3);

    // Run to 16 completed cycles: the 4-bit counter wraps to 0.
    for (int n = 3; n <= 15; n++) begin
      for (int ph = 1; ph <= 7; ph++) begin
        tick(); exp_a("wrap", 1'b1, ph, n);
      end
      tick(); exp_a("wrap", 1'b1, 0, n + 1);
    end
    check("wrap/b_zero", 32'(b_cyc_cnt), 32'd0);

    // Stall on the last phase blocks wrap, count and the halt request.
    for (int ph = 1; ph <= 7; ph++) begin
      tick(); exp_a("last_stall", 1'b1, ph, 16);
    end
    mode  = MODE_HALT;
    stall = 1'b1;
    repeat (2) begin
      tick(); exp_a("last_stall_hold", 1'b1, 7, 16);
    end
    stall = 1'b0;
    tick(); exp_a("last_stall_wait", 1'b0, 0, 17);
    check("last_stall/state", 32'(a_dbg_state), 32'(ST_WAIT));
    mode = MODE_RUN;
    tick(); exp_a("resume1", 1'b1, 0, 17);

    // Halt requested at phase 4: cycle completes, then WAIT, then resume.
    for (int ph = 1; ph <= 4; ph++) begin
      tick(); exp_a("halt_pre", 1'b1, ph, 17);
    end
    mode = MODE_HALT;
    for (int ph = 5; ph <= 7; ph++) begin
      tick(); exp_a("halt_finish", 1'b1, ph, 17);
    end
    tick(); exp_a("halt_wait", 1'b0, 0, 18);
    check("halt/state", 32'(a_dbg_state), 32'(ST_WAIT));
    tick(); exp_a("halt_wait2", 1'b0, 0, 18);
    mode = MODE_RUN;
    tick(); exp_a("resume2", 1'b1, 0, 18);

    // Reset at phase 5 aborts the cycle with no partial count.
    for (int ph = 1; ph <= 5; ph++) begin
      tick(); exp_a("mid_rst_pre", 1'b1, ph, 18);
    end
    rst = 1'b1;
    tick(); exp_a("mid_rst", 1'b0, 0, 0);
    check("mid_rst/state", 32'(a_dbg_state), 32'(ST_IDLE));

    // Single step from reset.
    rst  = 1'b0;
    mode = MODE_STEP;
    tick(); exp_a("step_idle", 1'b0, 0, 0);
    check("step_idle/state", 32'(a_dbg_state), 32'(ST_IDLE));
    tick(); exp_a("step_wait", 1'b0, 0, 0);
    check("step_wait/state", 32'(a_dbg_state), 32'(ST_WAIT));
    tick(); exp_a("step_wait2", 1'b0, 0, 0);
    step = 1'b1;
    tick(); exp_a("step_go", 1'b1, 0, 0);
    step = 1'b0;
    for (int ph = 1; ph <= 7; ph++) begin
      if (ph == 3) step = 1'b1;
      tick(); exp_a("step_run", 1'b1, ph, 0);
      step = 1'b0;
    end
    tick(); exp_a("step_done", 1'b0, 0, 1);
    check("step_done/state", 32'(a_dbg_state), 32'(ST_WAIT));
    repeat (2) begin
      tick(); exp_a("step_idle_wait", 1'b0, 0, 1);
    end
    mode = MODE_HALT;
    step = 1'b1;
    tick(); exp_a("halt_step", 1'b0, 0, 1);
    mode = 2'b11;
    tick(); exp_a("mode3_step", 1'b0, 0, 1);
    step = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
